// File: rtl/iir_notch_biquad.sv
// iir_notch_biquad: DF-I biquad, one shared multiplier over five MAC cycles, shadowed coefficients.
// Define IIR_SAT_CNT_EN to add the o_sat_count saturation event counter.
module iir_notch_biquad #(
   parameter int DATA_WIDTH  = 16,
   parameter int DATA_FRAC   = 15,
   parameter int COEFF_WIDTH = 20,
   parameter int COEFF_FRAC  = 18,
   parameter int ACC_WIDTH   = 40
) (
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   input  logic                               i_valid_in,
   input  logic signed [DATA_WIDTH-1:0]       i_filter_in,
   input  logic                               i_bypass,
   input  logic                               i_coeff_wr_en,
   input  logic [4:0][COEFF_WIDTH-1:0]        i_coeff_data_in,
   output logic [4:0][COEFF_WIDTH-1:0]        o_coeff_data_out,
   output logic signed [DATA_WIDTH-1:0]       o_filter_out,
   output logic                               o_valid_out,
   output logic                               o_overflow,
   output logic                               o_underflow,
`ifdef IIR_SAT_CNT_EN
   output logic                               o_drop_err,
   output logic [7:0]                         o_sat_count
`else
   output logic                               o_drop_err
`endif
);
   typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, MAC3, MAC4, SAT} state_t;
   localparam int PW = DATA_WIDTH + COEFF_WIDTH;
   localparam logic signed [ACC_WIDTH-1:0] RND  = ACC_WIDTH'(1 << (COEFF_FRAC - 1));
   localparam logic signed [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
   localparam logic signed [ACC_WIDTH-1:0] SMIN = -SMAX - 1;
   localparam logic [4:0][COEFF_WIDTH-1:0] COEFF_RST = {{(4*COEFF_WIDTH){1'b0}}, COEFF_WIDTH'(1 << COEFF_FRAC)};
   state_t r_state, w_next;
   logic signed [DATA_WIDTH-1:0]  r_x, r_x1, r_x2, r_y1, r_y2, r_out, w_x, w_y;
   logic signed [COEFF_WIDTH-1:0] w_c;
   logic signed [PW-1:0]          w_prod;
   logic signed [ACC_WIDTH-1:0]   r_acc, w_term, w_sum, w_rnd;
   logic [4:0][COEFF_WIDTH-1:0]   r_shadow, r_act;
   logic r_valid, r_ovf, r_unf, r_drop, w_ovf, w_unf, w_drop;
   always_comb begin
      w_x    = r_state == MAC0 ? r_x : r_state == MAC1 ? r_x1 : r_state == MAC2 ? r_x2 :
               r_state == MAC3 ? r_y1 : r_y2;
      w_c    = r_state == MAC0 ? r_act[0] : r_state == MAC1 ? r_act[1] : r_state == MAC2 ? r_act[2] :
               r_state == MAC3 ? r_act[3] : r_act[4];
      w_prod = w_x * w_c;
      w_term = {{(ACC_WIDTH-PW){w_prod[PW-1]}}, w_prod};
      w_sum  = r_acc + RND;
      w_rnd  = w_sum >>> COEFF_FRAC;
      w_ovf  = w_rnd > SMAX;
      w_unf  = w_rnd < SMIN;
      w_y    = w_ovf ? {1'b0, {(DATA_WIDTH-1){1'b1}}} : w_unf ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
               w_rnd[DATA_WIDTH-1:0];
      w_drop = i_valid_in && r_state != IDLE && !i_bypass;
      w_next = i_bypass ? IDLE : r_state == IDLE ? (i_valid_in ? MAC0 : IDLE) :
               r_state == SAT ? IDLE : state_t'(r_state + 3'd1);
   end
   always_ff @(posedge i_clk)
      if (!i_rst_n) r_state <= IDLE;
      else r_state <= w_next;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         {r_x, r_x1, r_x2, r_y1, r_y2, r_out} <= '0;
         r_acc    <= '0;
         r_shadow <= COEFF_RST;
         r_act    <= COEFF_RST;
         {r_valid, r_ovf, r_unf, r_drop} <= '0;
      end else begin
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
         if (i_coeff_wr_en) r_shadow <= i_coeff_data_in;
         if (w_drop) r_drop <= 1'b1;
         if (i_bypass) begin
            r_out   <= i_filter_in;
            r_valid <= i_valid_in;
            {r_x, r_x1, r_x2, r_y1, r_y2} <= '0;
            r_acc   <= '0;
         end else if (r_state == IDLE) begin
            if (i_valid_in) begin
               r_x   <= i_filter_in;
               r_act <= i_coeff_wr_en ? i_coeff_data_in : r_shadow;
               r_acc <= '0;
            end
         end else if (r_state == SAT) begin
            r_out   <= w_y;
            r_valid <= 1'b1;
            r_ovf   <= w_ovf;
            r_unf   <= w_unf;
            r_x2    <= r_x1;
            r_x1    <= r_x;
            r_y2    <= r_y1;
            r_y1    <= w_y;
         end else begin
            // feedback taps (a1, a2) are subtracted
            r_acc <= (r_state == MAC3 || r_state == MAC4) ? r_acc - w_term : r_acc + w_term;
         end
      end
   end
`ifdef IIR_SAT_CNT_EN
   logic [7:0] r_sat_cnt;
   always_ff @(posedge i_clk)
      if (!i_rst_n) r_sat_cnt <= '0;
      else if (!i_bypass && r_state == SAT && (w_ovf || w_unf) && r_sat_cnt != 8'hff)
         r_sat_cnt <= r_sat_cnt + 8'd1;
   assign o_sat_count = r_sat_cnt;
`endif
   assign o_coeff_data_out = r_shadow;
   assign o_filter_out     = r_out;
   assign o_valid_out      = r_valid;
   assign o_overflow       = r_ovf;
   assign o_underflow      = r_unf;
   assign o_drop_err       = r_drop;
endmodule

// File: tb/tb_iir_notch_biquad.sv
// tb_iir_notch_biquad: directed vector table plus hand sequences for busy drop, coherence and bypass.
module tb_iir_notch_biquad;
   logic clk = 1'b0;
   logic rst_n, vin, byp, wr;
   logic signed [15:0] fin;
   logic [4:0][19:0] cdata, cout;
   logic signed [15:0] fout;
   logic vout, ovf, unf, drop;
   int total = 0, bad = 0;
`ifdef IIR_SAT_CNT_EN
   logic [7:0] scnt;
`endif
   always #5 clk = ~clk;
   iir_notch_biquad dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid_in(vin), .i_filter_in(fin), .i_bypass(byp),
      .i_coeff_wr_en(wr), .i_coeff_data_in(cdata), .o_coeff_data_out(cout),
      .o_filter_out(fout), .o_valid_out(vout), .o_overflow(ovf), .o_underflow(unf),
`ifdef IIR_SAT_CNT_EN
      .o_drop_err(drop), .o_sat_count(scnt)
`else
      .o_drop_err(drop)
`endif
   );
   typedef struct {
      logic               wr;
      logic               clr;
      logic signed [19:0] b0;
      logic signed [19:0] a1;
      logic signed [15:0] x;
      logic signed [15:0] y;
      logic               ov;
      logic               un;
   } vec_t;
   vec_t tv[10];
   task automatic chk(input string n, input int a, input int e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask
   task automatic setc(input logic signed [19:0] b0, input logic signed [19:0] a1);
      @(negedge clk);
      wr = 1'b1;
      cdata = '0;
      cdata[0] = b0;
      cdata[3] = a1;
      @(negedge clk);
      wr = 1'b0;
   endtask
   task automatic clr_hist();
      @(negedge clk);
      byp = 1'b1;
      @(negedge clk);
      byp = 1'b0;
   endtask
   task automatic send(input logic signed [15:0] x, output logic signed [15:0] y,
                       output logic ov, output logic un, output int lat);
      y = '0; ov = 1'b0; un = 1'b0; lat = 0;
      @(negedge clk);
      vin = 1'b1;
      fin = x;
      @(posedge clk);
      #1 vin = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (vout) begin
            lat = n; y = fout; ov = ovf; un = unf;
            break;
         end
      end
   endtask
   task automatic wait_out(output logic signed [15:0] y, output int lat);
      y = '0; lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (vout) begin
            lat = n; y = fout;
            break;
         end
      end
   endtask
   initial begin
      logic signed [15:0] y;
      logic ov, un;
      int lat, pulses;
      tv[0] = '{1'b0, 1'b0, 20'sd262144,  20'sd0,      16'sd16384,  16'sd16384,  1'b0, 1'b0};
      tv[1] = '{1'b1, 1'b1, 20'sd131072, -20'sd131072, 16'sd16384,  16'sd8192,   1'b0, 1'b0};
      tv[2] = '{1'b0, 1'b0, 20'sd0,       20'sd0,      16'sd0,      16'sd4096,   1'b0, 1'b0};
      tv[3] = '{1'b0, 1'b0, 20'sd0,       20'sd0,      16'sd0,      16'sd2048,   1'b0, 1'b0};
      tv[4] = '{1'b0, 1'b0, 20'sd0,       20'sd0,      16'sd0,      16'sd1024,   1'b0, 1'b0};
      tv[5] = '{1'b1, 1'b1, 20'sd393216,  20'sd0,      16'sd32767,  16'sd32767,  1'b1, 1'b0};
      tv[6] = '{1'b0, 1'b0, 20'sd0,       20'sd0,     -16'sd32768, -16'sd32768,  1'b0, 1'b1};
      tv[7] = '{1'b1, 1'b1, 20'sd131072,  20'sd0,      16'sd1,      16'sd1,      1'b0, 1'b0};
      tv[8] = '{1'b0, 1'b0, 20'sd0,       20'sd0,     -16'sd1,      16'sd0,      1'b0, 1'b0};
      tv[9] = '{1'b0, 1'b0, 20'sd0,       20'sd0,      16'sd3,      16'sd2,      1'b0, 1'b0};
      rst_n = 1'b0; vin = 1'b0; byp = 1'b0; wr = 1'b0; fin = '0; cdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", fout, 0);
      chk("rst_valid", vout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_unf", unf, 0);
      chk("rst_drop", drop, 0);
      chk("rst_b0", cout[0], 262144);
      chk("rst_b1", cout[1], 0);
      chk("rst_a1", cout[3], 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (tv[i].wr) setc(tv[i].b0, tv[i].a1);
         if (tv[i].clr) clr_hist();
         send(tv[i].x, y, ov, un, lat);
         chk($sformatf("vec%0d_y", i), y, tv[i].y);
         chk($sformatf("vec%0d_lat", i), lat, 6);
         chk($sformatf("vec%0d_ovf", i), ov, tv[i].ov);
         chk($sformatf("vec%0d_unf", i), un, tv[i].un);
`ifdef IIR_SAT_CNT_EN
         if (i == 6) chk("sat_count", scnt, 2);
`endif
      end
      // coefficient write landing mid-computation only affects the next sample
      setc(20'sd262144, 20'sd0);
      clr_hist();
      @(negedge clk);
      vin = 1'b1;
      fin = 16'sd16384;
      @(posedge clk);
      #1 vin = 1'b0;
      @(posedge clk);
      @(negedge clk);
      wr = 1'b1;
      cdata = '0;
      cdata[0] = 20'sd131072;
      @(posedge clk);
      #1 wr = 1'b0;
      chk("shadow_rb", cout[0], 131072);
      wait_out(y, lat);
      chk("coh_old_y", y, 16384);
      chk("coh_old_lat", lat, 4);
      send(16'sd16384, y, ov, un, lat);
      chk("coh_new_y", y, 8192);
      // bypass at E3 discards the in-flight sample
      @(negedge clk);
      vin = 1'b1;
      fin = 16'sd1000;
      @(posedge clk);
      #1 vin = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      byp = 1'b1;
      pulses = 0;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk);
         #1 if (vout) pulses++;
      end
      chk("byp_discard", pulses, 0);
      @(negedge clk);
      vin = 1'b1;
      fin = -16'sd5;
      @(posedge clk);
      #1;
      chk("byp_valid", vout, 1);
      chk("byp_y", fout, -5);
      chk("byp_ovf", ovf, 0);
      vin = 1'b0;
      @(posedge clk);
      #1 chk("byp_valid_end", vout, 0);
      @(negedge clk);
      byp = 1'b0;
      send(16'sd100, y, ov, un, lat);
      chk("resume_y", y, 50);
      chk("resume_lat", lat, 6);
      chk("drop_before", drop, 0);
      // second valid_in at E3 is dropped
      @(negedge clk);
      vin = 1'b1;
      fin = 16'sd2000;
      @(posedge clk);
      #1 vin = 1'b0;
      pulses = 0;
      lat = 0;
      for (int n = 1; n <= 15; n++) begin
         if (n == 3) begin
            @(negedge clk);
            vin = 1'b1;
            fin = 16'sd7000;
         end
         @(posedge clk);
         #1 vin = 1'b0;
         if (vout) begin
            pulses++;
            if (lat == 0) lat = n;
            y = fout;
         end
      end
      chk("busy_pulses", pulses, 1);
      chk("busy_lat", lat, 6);
      chk("busy_y", y, 1000);
      chk("drop_set", drop, 1);
      repeat (5) @(posedge clk);
      #1 chk("drop_sticky", drop, 1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1 chk("drop_rst", drop, 0);
      chk("rst_b0_again", cout[0], 262144);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
